// File: rtl/alu_if.sv
// Decode->execute and execute->memory handshake interfaces for the RV32I
// execute-stage ALU. Both are plain valid/ready bundles on the pipeline clock.

interface decode_execute_if #(parameter int N = 32);
    typedef struct packed {
        logic [6:0]   opcode;
        logic [2:0]   funct3;
        logic [6:0]   funct7;
        logic [N-1:0] reg_A;
        logic [N-1:0] reg_B;
        logic [N-1:0] imm_extended;
    } decoded_instr_t;

    logic           valid;
    logic           ready;
    decoded_instr_t decoded_instr;

    // ALU side: consumes the decoded instruction, back-pressures decode
    modport decode_out (
        input  valid,
        input  decoded_instr,
        output ready
    );
endinterface

interface execute_memory_if #(parameter int N = 32);
    logic         ready;
    logic         valid;
    logic [N-1:0] alu_result;

    // ALU side: presents the registered result to the memory stage
    modport execute_out (
        input  ready,
        output valid,
        output alu_result
    );
endinterface

// File: rtl/alu.sv
// Execute-stage ALU: one registered result per accepted decoded instruction,
// single-cycle latency. A downstream stall propagates straight back to decode.
// Optional macro ALU_BRANCH_CMP_EN adds branch-condition evaluation on
// OPCODE_BRANCH; without it branches fall into the "unknown opcode -> 0" path.

module alu #(
    parameter int N = 32
) (
    input logic                    clk,
    input logic                    rst,
    decode_execute_if.decode_out   de_if,
    execute_memory_if.execute_out  em_if
);
    localparam int SHW = $clog2(N);

    localparam logic [6:0] OPCODE_REG_REG = 7'b0110011;
    localparam logic [6:0] OPCODE_REG_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_LOAD    = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE   = 7'b0100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [6:0] F7_SUB_SRA = 7'b0100000;

`ifdef ALU_BRANCH_CMP_EN
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;
`endif

    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [N-1:0]   imm;
    logic [6:0]     opcode;
    logic [2:0]     funct3;
    logic           alt;
    logic [SHW-1:0] shamt;
    logic [N-1:0]   result;

    // Decoded field aliases and operand-B selection
    always_comb begin
        opcode = de_if.decoded_instr.opcode;
        funct3 = de_if.decoded_instr.funct3;
        alt    = (de_if.decoded_instr.funct7 == F7_SUB_SRA);
        a      = de_if.decoded_instr.reg_A;
        imm    = de_if.decoded_instr.imm_extended;
        b      = (opcode == OPCODE_REG_REG) ? de_if.decoded_instr.reg_B : imm;
        shamt  = b[SHW-1:0];
    end

    // Result selection; unknown opcodes still produce a (zero) result
    always_comb begin
        result = '0;
        case (opcode)
            OPCODE_REG_REG, OPCODE_REG_IMM: begin
                case (funct3)
                    F3_ADD_SUB: result = alt ? (a - b) : (a + b);
                    F3_SLL:     result = a << shamt;
                    F3_SLT:     result = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
                    F3_SLTU:    result = {{(N-1){1'b0}}, (a < b)};
                    F3_XOR:     result = a ^ b;
                    F3_SRL_SRA: result = alt ? N'($signed(a) >>> shamt) : (a >> shamt);
                    F3_OR:      result = a | b;
                    F3_AND:     result = a & b;
                    default:    result = '0;
                endcase
            end
            OPCODE_LOAD, OPCODE_STORE: result = a + imm;
`ifdef ALU_BRANCH_CMP_EN
            OPCODE_BRANCH: begin
                // Branches compare two registers, so use reg_B, not the immediate
                case (funct3)
                    F3_BEQ:  result = {{(N-1){1'b0}}, (a == de_if.decoded_instr.reg_B)};
                    F3_BNE:  result = {{(N-1){1'b0}}, (a != de_if.decoded_instr.reg_B)};
                    F3_BLT:  result = {{(N-1){1'b0}}, ($signed(a) <  $signed(de_if.decoded_instr.reg_B))};
                    F3_BGE:  result = {{(N-1){1'b0}}, ($signed(a) >= $signed(de_if.decoded_instr.reg_B))};
                    F3_BLTU: result = {{(N-1){1'b0}}, (a <  de_if.decoded_instr.reg_B)};
                    F3_BGEU: result = {{(N-1){1'b0}}, (a >= de_if.decoded_instr.reg_B)};
                    default: result = '0;
                endcase
            end
`endif
            default: result = '0;
        endcase
    end

    // Decode may only hand over an instruction when memory can take the result
    assign de_if.ready = em_if.ready;

    // Output register: update on accept, drop valid on idle, freeze on stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            em_if.valid      <= 1'b0;
            em_if.alu_result <= '0;
        end else if (em_if.ready) begin
            em_if.valid <= de_if.valid;
            if (de_if.valid) em_if.alu_result <= result;
        end
    end
endmodule

// File: tb/tb_alu.sv
// Bench for the execute-stage ALU: directed vectors plus randomized traffic,
// with a scoreboard queue filled by the driver and drained by a monitor.

module tb_alu;
    localparam logic [6:0] OP_RR  = 7'b0110011;
    localparam logic [6:0] OP_RI  = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] F7_ALT = 7'b0100000;
    localparam longint     M32    = 64'h0000_0001_0000_0000;

    logic clk;
    logic rst;

    decode_execute_if #(.N(32)) de();
    execute_memory_if #(.N(32)) em();

    alu #(.N(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .de_if (de),
        .em_if (em)
    );

    int checks   = 0;
    int failures = 0;
    logic [31:0] sb_q[$];
    logic [31:0] last_exp;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [31:0] exp;
    } vec_t;
    vec_t vt[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
        end
    endfunction

    // Reference: arithmetic on 64-bit integers, reduced modulo 2^32
    function automatic logic [31:0] model(input logic [6:0] op, input logic [2:0] f3,
                                          input logic [6:0] f7, input logic [31:0] a,
                                          input logic [31:0] rb, input logic [31:0] imm);
        longint ua, ub, sa, sb, r;
        int sh;
        ua = longint'(a);
        ub = (op == OP_RR) ? longint'(rb) : longint'(imm);
        sa = (ua >= M32 / 2) ? ua - M32 : ua;
        sb = (ub >= M32 / 2) ? ub - M32 : ub;
        sh = int'(ub % 32);
        r  = 0;
        if (op == OP_RR || op == OP_RI) begin
            case (f3)
                3'd0: r = (f7 == F7_ALT) ? ua - ub : ua + ub;
                3'd1: r = ua * (longint'(1) << sh);
                3'd2: r = (sa < sb) ? 1 : 0;
                3'd3: r = (ua < ub) ? 1 : 0;
                3'd4: r = ua ^ ub;
                3'd5: r = (f7 == F7_ALT) ? (sa >>> sh) : (ua / (longint'(1) << sh));
                3'd6: r = ua | ub;
                default: r = ua & ub;
            endcase
        end else if (op == OP_LD || op == OP_ST) begin
            r = ua + longint'(imm);
        end
`ifdef ALU_BRANCH_CMP_EN
        else if (op == OP_BR) begin
            longint sr;
            ub = longint'(rb);
            sr = (ub >= M32 / 2) ? ub - M32 : ub;
            case (f3)
                3'd0: r = (ua == ub) ? 1 : 0;
                3'd1: r = (ua != ub) ? 1 : 0;
                3'd4: r = (sa <  sr) ? 1 : 0;
                3'd5: r = (sa >= sr) ? 1 : 0;
                3'd6: r = (ua <  ub) ? 1 : 0;
                3'd7: r = (ua >= ub) ? 1 : 0;
                default: r = 0;
            endcase
        end
`endif
        r = r % M32;
        if (r < 0) r = r + M32;
        return r[31:0];
    endfunction

    // Drive one cycle of inputs just after a rising edge; record expected on accept
    task automatic drive(input logic v, input logic rdy, input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic [31:0] exp);
        @(posedge clk);
        #1;
        de.valid                      = v;
        em.ready                      = rdy;
        de.decoded_instr.opcode       = op;
        de.decoded_instr.funct3       = f3;
        de.decoded_instr.funct7       = f7;
        de.decoded_instr.reg_A        = a;
        de.decoded_instr.reg_B        = b;
        de.decoded_instr.imm_extended = imm;
        if (v && rdy) begin
            sb_q.push_back(exp);
            last_exp = exp;
        end
    endtask

    task automatic idle(input logic rdy);
        drive(1'b0, rdy, 7'h0, 3'h0, 7'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst      = 1'b1;
        de.valid = 1'b0;
        sb_q.delete();
        #1;
        chk("rst_async_valid", 32'(em.valid), 32'd0);
        chk("rst_async_result", em.alu_result, 32'd0);
        @(posedge clk);
        #1;
        chk("rst_hold_result", em.alu_result, 32'd0);
        rst = 1'b0;
    endtask

    function automatic void add(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                                input logic [31:0] exp);
        vec_t v;
        v.op = op; v.f3 = f3; v.f7 = f7; v.a = a; v.b = b; v.imm = imm; v.exp = exp;
        vt.push_back(v);
    endfunction

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: a result is consumed on each edge where valid and ready are both high
    always @(negedge clk) begin
        if (!rst && em.valid && em.ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result actual=%h required=none", em.alu_result);
            end else begin
                chk("result", em.alu_result, sb_q.pop_front());
            end
        end
    end

    initial begin
        logic [31:0] br_exp;
        rst      = 1'b1;
        de.valid = 1'b0;
        em.ready = 1'b0;
        de.decoded_instr = '0;
        last_exp = 32'h0;
        #1;
        chk("reset_valid", 32'(em.valid), 32'd0);
        chk("reset_result", em.alu_result, 32'd0);
        em.ready = 1'b1;
        #1;
        chk("de_ready_follows_hi", 32'(de.ready), 32'd1);
        em.ready = 1'b0;
        #1;
        chk("de_ready_follows_lo", 32'(de.ready), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        add(OP_RR, 3'd0, 7'h00, 32'd5,          32'd3,          32'h1234_5678, 32'h8);
        add(OP_RR, 3'd0, F7_ALT, 32'd8,         32'd3,          32'h1234_5678, 32'h5);
        add(OP_RR, 3'd0, 7'h00, 32'h7FFF_FFFF,  32'd1,          32'h1234_5678, 32'h8000_0000);
        add(OP_RR, 3'd0, F7_ALT, 32'h8000_0000, 32'd1,          32'h1234_5678, 32'h7FFF_FFFF);
        add(OP_RR, 3'd6, 7'h00, 32'hA,          32'h5,          32'h1234_5678, 32'hF);
        add(OP_RR, 3'd7, 7'h00, 32'hA,          32'h5,          32'h1234_5678, 32'h0);
        add(OP_RR, 3'd4, 7'h00, 32'hA,          32'h5,          32'h1234_5678, 32'hF);
        add(OP_RR, 3'd2, 7'h00, 32'hFFFF_FFF5,  32'd5,          32'h1234_5678, 32'h1);
        add(OP_RR, 3'd2, 7'h00, 32'd5,          32'hFFFF_FFF5,  32'h1234_5678, 32'h0);
        add(OP_RR, 3'd3, 7'h00, 32'd3,          32'd5,          32'h1234_5678, 32'h1);
        add(OP_RR, 3'd3, 7'h00, 32'hFFFF_FFFF,  32'd1,          32'h1234_5678, 32'h0);
        add(OP_RI, 3'd0, 7'h00, 32'd0,          32'hDEAD_BEEF,  32'd5,         32'h5);
        add(OP_RI, 3'd0, F7_ALT, 32'd5,         32'hDEAD_BEEF,  32'd2,         32'h3);
        add(OP_RI, 3'd6, 7'h00, 32'h1010,       32'hDEAD_BEEF,  32'h0101,      32'h1111);
        add(OP_RI, 3'd7, 7'h00, 32'h1010,       32'hDEAD_BEEF,  32'h1000,      32'h1000);
        add(OP_RI, 3'd4, 7'h00, 32'h1010,       32'hDEAD_BEEF,  32'h0110,      32'h1100);
        add(OP_RI, 3'd1, 7'h00, 32'h1111,       32'hDEAD_BEEF,  32'd2,         32'h4444);
        add(OP_RI, 3'd5, 7'h00, 32'h1111,       32'hDEAD_BEEF,  32'd2,         32'h0444);
        add(OP_RI, 3'd5, F7_ALT, 32'hFFFF_FFF0, 32'hDEAD_BEEF,  32'd2,         32'hFFFF_FFFC);
        add(OP_LD, 3'd2, 7'h55, 32'h1000,       32'hDEAD_BEEF,  32'h10,        32'h1010);
        add(OP_ST, 3'd2, 7'h00, 32'h2000,       32'hDEAD_BEEF,  32'hFFFF_FFF0, 32'h1FF0);
        add(7'h7F, 3'd0, 7'h00, 32'd5,          32'd3,          32'd3,         32'h0);
`ifdef ALU_BRANCH_CMP_EN
        br_exp = 32'h1;
`else
        br_exp = 32'h0;
`endif
        add(OP_BR, 3'd0, 7'h00, 32'd5,          32'd5,          32'd9,         br_exp);

        foreach (vt[i])
            drive(1'b1, 1'b1, vt[i].op, vt[i].f3, vt[i].f7, vt[i].a, vt[i].b, vt[i].imm, vt[i].exp);

        // Idle after a result: valid drops, value holds
        idle(1'b1);
        @(posedge clk);
        #1;
        chk("idle_valid", 32'(em.valid), 32'd0);
        chk("idle_hold", em.alu_result, last_exp);

        // Stall: a pending instruction is not taken and the output freezes
        drive(1'b1, 1'b1, OP_RR, 3'd0, 7'h00, 32'd20, 32'd22, 32'd0, 32'd42);
        drive(1'b1, 1'b0, OP_RR, 3'd0, 7'h00, 32'd1, 32'd1, 32'd0, 32'd2);
        chk("stall_de_ready", 32'(de.ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("stall_valid", 32'(em.valid), 32'd1);
        chk("stall_hold", em.alu_result, 32'd42);
        idle(1'b1);

        // Reset with results in flight, then a first op after release
        drive(1'b1, 1'b1, OP_RR, 3'd4, 7'h00, 32'hFF00, 32'h0FF0, 32'd0, 32'hF0F0);
        drive(1'b1, 1'b1, OP_RR, 3'd6, 7'h00, 32'h1, 32'h2, 32'd0, 32'h3);
        do_reset();
        chk("post_rst_valid", 32'(em.valid), 32'd0);
        drive(1'b1, 1'b1, OP_LD, 3'd0, 7'h00, 32'h40, 32'h0, 32'h4, 32'h44);
        idle(1'b1);

        // Randomized traffic with random back-pressure and occasional reset
        for (int n = 0; n < 2000; n++) begin
            logic [6:0]  op;
            logic [2:0]  f3;
            logic [6:0]  f7;
            logic [31:0] a, b, imm;
            logic        v, rdy;
            case ($urandom_range(0, 7))
                0, 1, 2: op = OP_RR;
                3, 4:    op = OP_RI;
                5:       op = ($urandom_range(0, 1) != 0) ? OP_LD : OP_ST;
                6:       op = OP_BR;
                default: op = 7'($urandom);
            endcase
            f3  = 3'($urandom);
            f7  = ($urandom_range(0, 2) == 0) ? F7_ALT :
                  (($urandom_range(0, 5) == 0) ? 7'($urandom) : 7'h00);
            a   = rnd_val();
            b   = rnd_val();
            imm = rnd_val();
            v   = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 4) != 0);
            drive(v, rdy, op, f3, f7, a, b, imm, model(op, f3, f7, a, b, imm));
            if ($urandom_range(0, 399) == 0) do_reset();
        end

        // Drain remaining results
        for (int k = 0; k < 20 && sb_q.size() != 0; k++) idle(1'b1);
        idle(1'b1);
        @(posedge clk);
        #1;
        chk("drain_empty", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
